// File: rtl/vx_perf_memsys_dump_if.sv
// Memory-system performance counter bundle.
// The producer drives the fifteen counters and the dump engine samples them.
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

interface VX_perf_memsys_if #(
  parameter int CTR_BITS = `PERF_CTR_BITS
);
  logic [CTR_BITS-1:0] icache_reads;
  logic [CTR_BITS-1:0] icache_read_misses;
  logic [CTR_BITS-1:0] dcache_reads;
  logic [CTR_BITS-1:0] dcache_writes;
  logic [CTR_BITS-1:0] dcache_read_misses;
  logic [CTR_BITS-1:0] dcache_write_misses;
  logic [CTR_BITS-1:0] dcache_bank_stalls;
  logic [CTR_BITS-1:0] dcache_mshr_stalls;
  logic [CTR_BITS-1:0] smem_reads;
  logic [CTR_BITS-1:0] smem_writes;
  logic [CTR_BITS-1:0] smem_bank_stalls;
  logic [CTR_BITS-1:0] mem_reads;
  logic [CTR_BITS-1:0] mem_writes;
  logic [CTR_BITS-1:0] mem_latency;
  logic [CTR_BITS-1:0] w_count;

  modport master (
    output icache_reads, icache_read_misses,
    output dcache_reads, dcache_writes, dcache_read_misses, dcache_write_misses,
    output dcache_bank_stalls, dcache_mshr_stalls,
    output smem_reads, smem_writes, smem_bank_stalls,
    output mem_reads, mem_writes, mem_latency, w_count
  );

  modport slave (
    input icache_reads, icache_read_misses,
    input dcache_reads, dcache_writes, dcache_read_misses, dcache_write_misses,
    input dcache_bank_stalls, dcache_mshr_stalls,
    input smem_reads, smem_writes, smem_bank_stalls,
    input mem_reads, mem_writes, mem_latency, w_count
  );
endinterface

// File: rtl/vx_perf_memsys_dump.sv
// Memory-system counter dump engine.
// On an accepted request with a non-empty mask, all fifteen counters are
// snapshotted in one edge and the selected entries are streamed out one word
// per handshake in ascending index order. All outputs come from flops; the
// next-word values are precomputed from the next pending mask and snapshot.
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

module vx_perf_memsys_dump #(
  parameter int CTR_BITS      = `PERF_CTR_BITS,
  parameter int DUMP_CNT_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  VX_perf_memsys_if.slave          perf_memsys_if,
  input  logic                     req_valid,
  input  logic [14:0]              req_mask,
  output logic                     req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [3:0]               rsp_id,
  output logic [CTR_BITS-1:0]      rsp_data,
  output logic                     rsp_last,
  output logic                     busy,
  output logic [DUMP_CNT_BITS-1:0] dump_count
);

  localparam int NUM_CTRS = 15;

  typedef logic [CTR_BITS-1:0] ctr_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Index of the lowest set bit; scanning downward lets the lowest win.
  function automatic logic [3:0] lowest_idx(input logic [14:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NUM_CTRS - 1; i >= 0; i--) begin
      if (m[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // True when exactly one bit of the mask is set.
  function automatic logic is_onehot(input logic [14:0] m);
    return (m != 15'd0) && ((m & (m - 15'd1)) == 15'd0);
  endfunction

  ctr_t ctr_s [NUM_CTRS];

  state_e                   state_q, state_d;
  logic [14:0]              pend_q, pend_d;
  ctr_t                     snap_q [NUM_CTRS];
  ctr_t                     snap_d [NUM_CTRS];
  logic [DUMP_CNT_BITS-1:0] dump_cnt_q, dump_cnt_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [3:0]               rsp_id_q, rsp_id_d;
  ctr_t                     rsp_data_q, rsp_data_d;
  logic                     rsp_last_q, rsp_last_d;
  logic                     req_ready_q, req_ready_d;
  logic                     busy_q, busy_d;

  // Gather the counter sources into an index-addressable array.
  always_comb begin
    ctr_s[0]  = perf_memsys_if.icache_reads;
    ctr_s[1]  = perf_memsys_if.icache_read_misses;
    ctr_s[2]  = perf_memsys_if.dcache_reads;
    ctr_s[3]  = perf_memsys_if.dcache_writes;
    ctr_s[4]  = perf_memsys_if.dcache_read_misses;
    ctr_s[5]  = perf_memsys_if.dcache_write_misses;
    ctr_s[6]  = perf_memsys_if.dcache_bank_stalls;
    ctr_s[7]  = perf_memsys_if.dcache_mshr_stalls;
    ctr_s[8]  = perf_memsys_if.smem_reads;
    ctr_s[9]  = perf_memsys_if.smem_writes;
    ctr_s[10] = perf_memsys_if.smem_bank_stalls;
    ctr_s[11] = perf_memsys_if.mem_reads;
    ctr_s[12] = perf_memsys_if.mem_writes;
    ctr_s[13] = perf_memsys_if.mem_latency;
    ctr_s[14] = perf_memsys_if.w_count;
  end

  // Next-state logic: accept/snapshot in IDLE, retire one word per handshake in SEND.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    snap_d     = snap_q;
    dump_cnt_d = dump_cnt_q;
    case (state_q)
      ST_IDLE: begin
        // A zero mask is accepted but produces nothing.
        if (req_valid && (req_mask != 15'd0)) begin
          snap_d  = ctr_s;
          pend_d  = req_mask;
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (rsp_valid_q && rsp_ready) begin
          pend_d = pend_q & ~(15'd1 << rsp_id_q);
          if (rsp_last_q) begin
            pend_d     = 15'd0;
            state_d    = ST_IDLE;
            dump_cnt_d = dump_cnt_q + DUMP_CNT_BITS'(1);
          end else begin
            state_d = ST_SEND;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pend_d  = 15'd0;
      end
    endcase
  end

  // Precompute the registered outputs from the next state so they line up with it.
  always_comb begin
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d == ST_SEND);
    if (state_d == ST_SEND) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = lowest_idx(pend_d);
      rsp_data_d  = snap_d[rsp_id_d];
      rsp_last_d  = is_onehot(pend_d);
    end else begin
      rsp_valid_d = 1'b0;
      rsp_id_d    = 4'd0;
      rsp_data_d  = '0;
      rsp_last_d  = 1'b0;
    end
  end

  // State, snapshot and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pend_q      <= 15'd0;
      for (int i = 0; i < NUM_CTRS; i++) begin
        snap_q[i] <= '0;
      end
      dump_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 4'd0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      snap_q      <= snap_d;
      dump_cnt_q  <= dump_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_last   = rsp_last_q;
  assign dump_count = dump_cnt_q;

endmodule

// File: tb/tb_vx_perf_memsys_dump.sv
// Scoreboard bench for vx_perf_memsys_dump: stimulus pushes expected words,
// a negedge monitor compares every presented word against the queue head.
module tb_vx_perf_memsys_dump;

  localparam int CW = 44;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          req_valid;
  logic [14:0]   req_mask;
  logic          req_ready;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [3:0]    rsp_id;
  logic [CW-1:0] rsp_data;
  logic          rsp_last;
  logic          busy;
  logic [7:0]    dump_count;

  logic          req_valid2;
  logic [14:0]   req_mask2;
  logic          req_ready2;
  logic          rsp_valid2;
  logic          rsp_ready2;
  logic [3:0]    rsp_id2;
  logic [CW-1:0] rsp_data2;
  logic          rsp_last2;
  logic          busy2;
  logic [1:0]    dump_count2;

  logic [CW-1:0] ctr [15];

  VX_perf_memsys_if #(.CTR_BITS(CW)) pif();

  assign pif.icache_reads        = ctr[0];
  assign pif.icache_read_misses  = ctr[1];
  assign pif.dcache_reads        = ctr[2];
  assign pif.dcache_writes       = ctr[3];
  assign pif.dcache_read_misses  = ctr[4];
  assign pif.dcache_write_misses = ctr[5];
  assign pif.dcache_bank_stalls  = ctr[6];
  assign pif.dcache_mshr_stalls  = ctr[7];
  assign pif.smem_reads          = ctr[8];
  assign pif.smem_writes         = ctr[9];
  assign pif.smem_bank_stalls    = ctr[10];
  assign pif.mem_reads           = ctr[11];
  assign pif.mem_writes          = ctr[12];
  assign pif.mem_latency         = ctr[13];
  assign pif.w_count             = ctr[14];

  vx_perf_memsys_dump #(.CTR_BITS(CW), .DUMP_CNT_BITS(8)) dut (
    .clk(clk), .reset(reset), .perf_memsys_if(pif.slave),
    .req_valid(req_valid), .req_mask(req_mask), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy),
    .dump_count(dump_count)
  );

  assign rsp_ready2 = 1'b1;

  vx_perf_memsys_dump #(.CTR_BITS(CW), .DUMP_CNT_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .perf_memsys_if(pif.slave),
    .req_valid(req_valid2), .req_mask(req_mask2), .req_ready(req_ready2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_id(rsp_id2),
    .rsp_data(rsp_data2), .rsp_last(rsp_last2), .busy(busy2),
    .dump_count(dump_count2)
  );

  typedef struct packed {
    logic [3:0]    id;
    logic [CW-1:0] data;
    logic          last;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Push the expected word stream for a mask using the counters as they are now.
  task automatic push_dump(input logic [14:0] mask);
    int hi;
    exp_t e;
    hi = -1;
    for (int i = 0; i < 15; i++) if (mask[i]) hi = i;
    for (int i = 0; i < 15; i++) begin
      if (mask[i]) begin
        e.id   = 4'(i);
        e.data = ctr[i];
        e.last = (i == hi);
        sb_q.push_back(e);
      end
    end
  endtask

  // Wait for req_ready, present one request, drop it after the accept edge.
  task automatic accept(input logic [14:0] mask);
    int k;
    k = 0;
    while (!req_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("accept_ready", 64'(req_ready), 64'd1);
    push_dump(mask);
    req_valid = 1'b1;
    req_mask  = mask;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_mask  = 15'd0;
  endtask

  // Run until the scoreboard is empty and the engine is idle, optionally
  // toggling rsp_ready and bumping all counters each cycle.
  task automatic drain(input bit toggle, input bit incr, output int cyc);
    cyc = 0;
    do begin
      if (toggle) rsp_ready = ~rsp_ready;
      if (incr) for (int i = 0; i < 15; i++) ctr[i] = ctr[i] + 44'd1;
      @(posedge clk); #1;
      cyc++;
    end while (!(sb_q.size() == 0 && !busy) && cyc < 300);
    if (cyc >= 300) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending words expected 0", sb_q.size());
    end
  endtask

  // Monitor: compare the presented word with the queue head, pop on handshake.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got id %0d data 0x%0h expected no word", rsp_id, rsp_data);
      end else begin
        check("rsp_id", 64'(rsp_id), 64'(sb_q[0].id));
        check("rsp_data", 64'(rsp_data), 64'(sb_q[0].data));
        check("rsp_last", 64'(rsp_last), 64'(sb_q[0].last));
        if (rsp_ready) sb_q.delete(0);
      end
    end else begin
      check("idle_rsp_zero", 64'({rsp_id, rsp_data, rsp_last}), 64'd0);
    end
  end

  initial begin
    int cyc;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_mask   = 15'd0;
    rsp_ready  = 1'b1;
    req_valid2 = 1'b0;
    req_mask2  = 15'd0;
    for (int i = 0; i < 15; i++) ctr[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_dump_count", 64'(dump_count), 64'd0);
    check("rst_dump_count2", 64'(dump_count2), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Full dump at full throughput: data 7,107,...,1407 on 15 consecutive cycles.
    for (int i = 0; i < 15; i++) ctr[i] = 44'(i * 100 + 7);
    accept(15'h7FFF);
    check("t1_busy", 64'(busy), 64'd1);
    drain(1'b0, 1'b0, cyc);
    check("t1_cycles", 64'(cyc), 64'd15);
    check("t1_dump_count", 64'(dump_count), 64'd1);

    // Sparse mask with stalls while counters keep moving: snapshot values only.
    rsp_ready = 1'b0;
    accept(15'h4005);
    drain(1'b1, 1'b1, cyc);
    rsp_ready = 1'b1;
    check("t2_dump_count", 64'(dump_count), 64'd2);

    // Empty mask: accepted, nothing produced, count unchanged.
    req_valid = 1'b1;
    req_mask  = 15'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("t3_busy", 64'(busy), 64'd0);
    check("t3_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    check("t3_busy_later", 64'(busy), 64'd0);
    check("t3_dump_count", 64'(dump_count), 64'd2);

    // Request held during SEND: blocked until the edge after the last handshake.
    push_dump(15'h0003);
    push_dump(15'h0010);
    req_valid = 1'b1;
    req_mask  = 15'h0003;
    @(posedge clk); #1;
    req_mask = 15'h0010;
    check("t4_ready_word0", 64'(req_ready), 64'd0);
    check("t4_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("t4_ready_word1", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    check("t4_ready_after_last", 64'(req_ready), 64'd1);
    check("t4_count_first", 64'(dump_count), 64'd3);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_mask  = 15'd0;
    check("t4_second_busy", 64'(busy), 64'd1);
    drain(1'b0, 1'b0, cyc);
    check("t4_dump_count", 64'(dump_count), 64'd4);

    // Reset after three of eight words: dump aborted, count cleared.
    accept(15'h00FF);
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset     = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    check("t5_pending_words", 64'(sb_q.size()), 64'd5);
    sb_q.delete();
    check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t5_req_ready", 64'(req_ready), 64'd1);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_dump_count", 64'(dump_count), 64'd0);
    reset     = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_still_idle", 64'(busy), 64'd0);

    // Two-bit dump counter wraps: 1,2,3,0,1.
    for (int k = 0; k < 5; k++) begin
      req_valid2 = 1'b1;
      req_mask2  = 15'd1 << k;
      @(posedge clk); #1;
      req_valid2 = 1'b0;
      req_mask2  = 15'd0;
      @(posedge clk); #1;
      check("t6_dump_count2", 64'(dump_count2), 64'((k + 1) % 4));
      check("t6_busy2", 64'(busy2), 64'd0);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
